// File: rtl/crc16_tx_scheduler.sv
// rtl/crc16_tx_scheduler.sv - round-robin packet scheduler feeding a CRC16 encoder
// Two requesters share one encoder; each packet gets a send timeout and an inter-packet gap.
module crc16_tx_scheduler #(
  parameter int TIMEOUT = 200,
  parameter int GAP     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [1:0]  req,
  input  logic [71:0] pkt0,
  input  logic [71:0] pkt1,
  input  logic        enc_done,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic [71:0] enc_pkt,
  output logic        enc_pkt_ready,
  output logic        enc_abort,
  output logic        busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SEND, ST_GAP} state_t;

  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  GAP_LAST     = (GAP > 0) ? 8'(GAP - 1) : 8'd0;
  localparam state_t      ST_AFTER     = (GAP == 0) ? ST_IDLE : ST_GAP;

  state_t      state, state_nxt;
  logic        owner, owner_nxt;
  logic        ptr, ptr_nxt;
  logic        sel;
  logic [15:0] timer, timer_nxt;
  logic [7:0]  gap_cnt, gap_cnt_nxt;
  logic [71:0] enc_pkt_nxt;
  logic [1:0]  gnt_nxt, done_nxt, err_nxt;
  logic        enc_pkt_ready_nxt, enc_abort_nxt, busy_nxt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      owner         <= 1'b0;
      ptr           <= 1'b1;
      timer         <= 16'd0;
      gap_cnt       <= 8'd0;
      enc_pkt       <= 72'd0;
      gnt           <= 2'b00;
      done          <= 2'b00;
      err           <= 2'b00;
      enc_pkt_ready <= 1'b0;
      enc_abort     <= 1'b0;
      busy          <= 1'b0;
    end else begin
      state         <= state_nxt;
      owner         <= owner_nxt;
      ptr           <= ptr_nxt;
      timer         <= timer_nxt;
      gap_cnt       <= gap_cnt_nxt;
      enc_pkt       <= enc_pkt_nxt;
      gnt           <= gnt_nxt;
      done          <= done_nxt;
      err           <= err_nxt;
      enc_pkt_ready <= enc_pkt_ready_nxt;
      enc_abort     <= enc_abort_nxt;
      busy          <= busy_nxt;
    end
  end

  // On a tie the requester that was not served last wins.
  always_comb begin
    sel = 1'b0;
    case (req)
      2'b01:   sel = 1'b0;
      2'b10:   sel = 1'b1;
      2'b11:   sel = ~ptr;
      default: sel = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt         = state;
    owner_nxt         = owner;
    ptr_nxt           = ptr;
    timer_nxt         = timer;
    gap_cnt_nxt       = gap_cnt;
    enc_pkt_nxt       = enc_pkt;
    done_nxt          = 2'b00;
    err_nxt           = 2'b00;
    enc_pkt_ready_nxt = 1'b0;
    enc_abort_nxt     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (req != 2'b00) begin
          owner_nxt         = sel;
          enc_pkt_nxt       = sel ? pkt1 : pkt0;
          enc_pkt_ready_nxt = 1'b1;
          state_nxt         = ST_LOAD;
        end
      end
      ST_LOAD: begin
        timer_nxt = 16'd0;
        state_nxt = ST_SEND;
      end
      ST_SEND: begin
        timer_nxt = timer + 16'd1;
        // A completion in the timeout cycle still counts as a completion.
        if (enc_done) begin
          done_nxt    = owner ? 2'b10 : 2'b01;
          ptr_nxt     = owner;
          gap_cnt_nxt = 8'd0;
          state_nxt   = ST_AFTER;
        end else if (timer == TIMEOUT_LAST) begin
          err_nxt       = owner ? 2'b10 : 2'b01;
          enc_abort_nxt = 1'b1;
          ptr_nxt       = owner;
          gap_cnt_nxt   = 8'd0;
          state_nxt     = ST_AFTER;
        end
      end
      ST_GAP: begin
        if (gap_cnt == GAP_LAST) begin
          state_nxt = ST_IDLE;
        end else begin
          gap_cnt_nxt = gap_cnt + 8'd1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    gnt_nxt  = ((state_nxt == ST_LOAD) || (state_nxt == ST_SEND)) ?
               (owner_nxt ? 2'b10 : 2'b01) : 2'b00;
    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule
